// File: rtl/vmac_pkg.sv
// Shared types and sizing helpers for the vector MAC engine.
package vmac_pkg;

    typedef enum logic [1:0] {
        VMAC_DOT    = 2'd0,
        VMAC_SQDIST = 2'd1,
        VMAC_SUM    = 2'd2,
        VMAC_SUMSQ  = 2'd3
    } vmac_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vmac_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator width large enough that no mode can overflow over len terms.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned len);
        return 2 * width + 1 + clog2(len);
    endfunction

    // Element counter width; at least one bit so LEN=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned len);
        return (clog2(len) == 0) ? 1 : clog2(len);
    endfunction

endpackage

// File: rtl/vmac_term.sv
// Per-element term generator for the vector MAC engine.
// Build option VMAC_PIPE_EN: registers the term (and its valid) before the accumulator.
module vmac_term
    import vmac_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
`ifdef VMAC_PIPE_EN
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
`endif
    input  logic               fire,
    input  vmac_mode_e         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH:0]   term,
    output logic               term_valid
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned TERM_W = 2 * WIDTH + 1;

    logic [WIDTH-1:0]  diff;
    logic [PROD_W-1:0] prod_ab;
    logic [PROD_W-1:0] sq_a;
    logic [PROD_W-1:0] sq_b;
    logic [PROD_W-1:0] sq_d;
    logic [TERM_W-1:0] term_d;

    // Select the per-element term for the latched mode.
    always_comb begin
        diff    = (a >= b) ? (a - b) : (b - a);
        prod_ab = PROD_W'(a) * PROD_W'(b);
        sq_a    = PROD_W'(a) * PROD_W'(a);
        sq_b    = PROD_W'(b) * PROD_W'(b);
        sq_d    = PROD_W'(diff) * PROD_W'(diff);
        term_d  = '0;
        case (mode)
            VMAC_DOT:    term_d = TERM_W'(prod_ab);
            VMAC_SQDIST: term_d = TERM_W'(sq_d);
            VMAC_SUM:    term_d = TERM_W'(a) + TERM_W'(b);
            VMAC_SUMSQ:  term_d = TERM_W'(sq_a) + TERM_W'(sq_b);
            default:     term_d = '0;
        endcase
    end

`ifdef VMAC_PIPE_EN
    // Term pipeline register; valid marks a term still owed to the accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            term       <= '0;
            term_valid <= 1'b0;
        end else if (flush) begin
            term       <= '0;
            term_valid <= 1'b0;
        end else begin
            term_valid <= fire;
            if (fire) begin
                term <= term_d;
            end
        end
    end
`else
    assign term       = term_d;
    assign term_valid = fire;
`endif

endmodule

// File: rtl/vector_mac_engine.sv
// Vector reduction engine: accumulates LEN element-pair terms and returns a scalar.
// Build option VMAC_PIPE_EN: pipelined term path with a DRAIN state (one extra cycle of latency).
module vector_mac_engine
    import vmac_pkg::*;
#(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned LEN   = 8,
    localparam int unsigned ACC_W = acc_width(WIDTH, LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data_1,
    input  logic [WIDTH-1:0]  data_2,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    localparam int unsigned CNT_W  = cnt_width(LEN);
    localparam int unsigned TERM_W = 2 * WIDTH + 1;

    vmac_state_e       state;
    vmac_mode_e        mode_q;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [TERM_W-1:0] term;
    logic              term_valid;
    logic              accept;
    logic              last;
    logic [ACC_W-1:0]  acc_sum;

    // A pair is taken only in RUN while ready; clear drops a same-cycle offer.
    assign accept  = (state == RUN) && in_ready && in_valid && !clear;
    assign last    = (count == CNT_W'(LEN - 1));
    assign acc_sum = acc + (term_valid ? ACC_W'(term) : ACC_W'(0));

    vmac_term #(
        .WIDTH (WIDTH)
    ) u_term (
`ifdef VMAC_PIPE_EN
        .clk        (clk),
        .rst        (rst),
        .flush      (clear),
`endif
        .fire       (accept),
        .mode       (mode_q),
        .a          (data_1),
        .b          (data_2),
        .term       (term),
        .term_valid (term_valid)
    );

    // Controller FSM with registered handshake outputs and accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mode_q       <= VMAC_DOT;
            acc          <= '0;
            count        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= vmac_mode_e'(mode);
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (accept) begin
                        if (last) begin
                            count    <= '0;
                            in_ready <= 1'b0;
`ifdef VMAC_PIPE_EN
                            state    <= DRAIN;
`else
                            result       <= acc_sum;
                            result_valid <= 1'b1;
                            state        <= DONE;
`endif
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    acc          <= acc_sum;
                    result       <= acc_sum;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mac_engine.sv
// Self-checking bench for vector_mac_engine (WIDTH=24, LEN=4), scoreboard based.
module tb_vector_mac_engine;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned LEN   = 4;
    localparam int unsigned ACC_W = 2 * WIDTH + 1 + 2;

    typedef logic [WIDTH-1:0] vec_t [LEN];

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] data_1 = '0;
    logic [WIDTH-1:0] data_2 = '0;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] sb [$];

    vector_mac_engine #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_1       (data_1),
        .data_2       (data_2),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_handshake in_ready=%b busy=%b required 1 1", in_ready, busy);
        end
    endtask

    task automatic feed(input vec_t a, input vec_t b, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL feed_timeout in_ready=%b required 1", in_ready);
                return;
            end
            in_valid = 1'b1;
            data_1   = a[i];
            data_2   = b[i];
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic get_result(output logic [ACC_W-1:0] r, output bit ok);
        int t;
        t = 0;
        while (!result_valid && t < 20) begin
            tick();
            t++;
        end
        ok = result_valid;
        r  = result;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b busy=%b result_valid=%b result=%h required all 0",
                     in_ready, busy, result_valid, result);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_dot;
        vec_t a = '{24'd1, 24'd10, 24'd40, 24'd3};
        vec_t b = '{24'd2, 24'd30, 24'd77, 24'd5};
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] exp;
        bit ok;
        sb.push_back(ACC_W'(3397));
        do_start(2'd0);
        feed(a, b, LEN, 0);
`ifdef VMAC_PIPE_EN
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL dot_latency_early result_valid=%b required 0", result_valid);
        end
        tick();
`endif
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL dot_latency result_valid=%b required 1", result_valid);
        end
        get_result(r, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || r !== exp) begin
            errors++;
            $display("FAIL dot_result got=%0d valid=%b required %0d", r, ok, exp);
        end
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dot_release result_valid=%b busy=%b required 0 0", result_valid, busy);
        end
    endtask

    task automatic test_sqdist;
        vec_t a = '{24'd5, 24'd0, 24'd100, 24'd7};
        vec_t b = '{24'd2, 24'd9, 24'd100, 24'd7};
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] exp;
        bit ok;
        sb.push_back(ACC_W'(90));
        do_start(2'd1);
        feed(a, b, LEN, 0);
        get_result(r, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || r !== exp) begin
            errors++;
            $display("FAIL sqdist_result got=%0d valid=%b required %0d", r, ok, exp);
        end
    endtask

    task automatic test_sumsq_max;
        vec_t a = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] exp;
        bit ok;
        sb.push_back(51'h7FFFFF0000008);
        do_start(2'd3);
        feed(a, a, LEN, 0);
        get_result(r, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || r !== exp) begin
            errors++;
            $display("FAIL sumsq_max got=%h valid=%b required %h", r, ok, exp);
        end
    endtask

    task automatic test_backpressure;
        vec_t a = '{24'd1, 24'd2, 24'd3, 24'd4};
        vec_t b = '{24'd5, 24'd6, 24'd7, 24'd8};
        logic [ACC_W-1:0] hold;
        logic [ACC_W-1:0] exp;
        int t;
        sb.push_back(ACC_W'(70));
        do_start(2'd0);
        feed(a, b, LEN, 2);
        t = 0;
        while (!result_valid && t < 20) begin
            tick();
            t++;
        end
        hold = result;
        exp  = sb.pop_front();
        checks++;
        if (result_valid !== 1'b1 || hold !== exp) begin
            errors++;
            $display("FAIL bp_result got=%0d valid=%b required %0d", hold, result_valid, exp);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result !== hold || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d valid=%b result=%0d in_ready=%b busy=%b required 1 %0d 0 1",
                         i, result_valid, result, in_ready, busy, hold);
            end
            start = (i == 1);
            mode  = 2'd2;
            tick();
            start = 1'b0;
        end
        checks++;
        if (result_valid !== 1'b1 || result !== hold || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_start valid=%b result=%0d in_ready=%b busy=%b required 1 %0d 0 1",
                     result_valid, result, in_ready, busy, hold);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release valid=%b busy=%b in_ready=%b required 0 0 0",
                     result_valid, busy, in_ready);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_start_ignored busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        vec_t a = '{24'd9, 24'd9, 24'd9, 24'd9};
        vec_t s1 = '{24'd1, 24'd2, 24'd3, 24'd4};
        vec_t s2 = '{24'd4, 24'd3, 24'd2, 24'd1};
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] exp;
        bit ok;
        do_start(2'd0);
        feed(a, a, 2, 0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL async_reset in_ready=%b busy=%b valid=%b result=%0d required all 0",
                     in_ready, busy, result_valid, result);
        end
        #2;
        rst = 1'b1;
        tick();
        sb.push_back(ACC_W'(20));
        do_start(2'd2);
        feed(s1, s2, LEN, 0);
        get_result(r, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || r !== exp) begin
            errors++;
            $display("FAIL sum_after_reset got=%0d valid=%b required %0d", r, ok, exp);
        end
    endtask

    task automatic test_clear;
        vec_t a = '{24'd7, 24'd7, 24'd7, 24'd7};
        vec_t ones = '{24'd1, 24'd1, 24'd1, 24'd1};
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] exp;
        bit ok;
        do_start(2'd0);
        feed(a, a, 3, 0);
        in_valid = 1'b1;
        data_1   = 24'd7;
        data_2   = 24'd7;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle busy=%b in_ready=%b valid=%b required 0 0 0",
                     busy, in_ready, result_valid);
        end
        repeat (3) tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_result valid=%b busy=%b required 0 0", result_valid, busy);
        end
        sb.push_back(ACC_W'(4));
        do_start(2'd0);
        feed(ones, ones, LEN, 0);
        get_result(r, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || r !== exp) begin
            errors++;
            $display("FAIL dot_after_clear got=%0d valid=%b required %0d", r, ok, exp);
        end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_sqdist();
        test_sumsq_max();
        test_backpressure();
        test_reset_mid();
        test_clear();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
